// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request, data bus and response signals of the load/store unit
interface mem_access_unit_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [1:0]        dreq_size;
  logic [NB-1:0]     dreq_strobe;
  logic [XLEN-1:0]   dreq_data;

  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [XLEN-1:0]   dresp_data;

  logic              down_stall;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_misalign;
  logic              busy;

  // Unit side: takes requests, drives the bus, returns results
  modport slave (
    input  req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  down_stall,
    output rsp_valid, rsp_data, rsp_misalign, busy
  );

  // Environment side: pipeline plus bus slave
  modport master (
    output req_valid, req_load, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output down_stall,
    input  rsp_valid, rsp_data, rsp_misalign, busy
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit with held bus request and registered result; optional MEM_MISALIGN_EN
module mem_access_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus
);
  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, DATA, HOLD} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [OFS-1:0]    ofs_q;
  logic              uns_q;
  logic              store_q;
  logic [XLEN-1:0]   data_q;
  logic [NB-1:0]     strobe_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              dreq_valid_q;
  logic              rsp_valid_q;
  logic              busy_q;
  logic              ready_q;
`ifdef MEM_MISALIGN_EN
  logic              misalign_q;
`endif

  logic [1:0]        eff_size;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W-1:0] aligned_addr;
  logic              misaligned;
  logic [OFS-1:0]    req_ofs;
  logic [3:0]        nbytes;
  logic [2*NB-1:0]   lanes_mask;
  logic [2*NB-1:0]   strobe_wide;
  logic [XLEN-1:0]   st_data;
  logic [NB-1:0]     st_strobe;
  logic              accept;

  // Request decode: effective size, alignment, shifted store data and byte strobes
  always_comb begin
    eff_size = bus.req_size;
    if (XLEN == 32 && bus.req_size == 2'd3) eff_size = 2'd2;
    size_mask  = (ADDR_W'(1) << eff_size) - ADDR_W'(1);
    misaligned = |(bus.req_addr & size_mask);
`ifdef MEM_MISALIGN_EN
    aligned_addr = bus.req_addr;
`else
    aligned_addr = bus.req_addr & ~size_mask;
`endif
    req_ofs     = aligned_addr[OFS-1:0];
    nbytes      = 4'd1 << eff_size;
    lanes_mask  = ((2*NB)'(1) << nbytes) - (2*NB)'(1);
    strobe_wide = lanes_mask << req_ofs;
    st_strobe   = strobe_wide[NB-1:0];
    st_data     = bus.req_wdata << {req_ofs, 3'b000};
    accept      = bus.req_valid & ready_q & (bus.req_load | bus.req_store);
  end

  logic [XLEN-1:0] ld_shift;
  logic [6:0]      nbits;
  logic [XLEN-1:0] ld_mask;
  logic [XLEN-1:0] ld_top;
  logic            ld_sign;
  logic [XLEN-1:0] ld_ext;

  // Load lane extraction and sign/zero extension from the top bit of the accessed size
  always_comb begin
    ld_shift = bus.dresp_data >> {ofs_q, 3'b000};
    nbits    = 7'd8 << size_q;
    ld_mask  = (int'(nbits) >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    ld_top   = ld_mask & ~(ld_mask >> 1);
    ld_sign  = |(ld_shift & ld_top);
    ld_ext   = (ld_shift & ld_mask) | ((ld_sign & ~uns_q) ? ~ld_mask : '0);
  end

  // Transaction FSM with all bus and response outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      ofs_q        <= '0;
      uns_q        <= 1'b0;
      store_q      <= 1'b0;
      data_q       <= '0;
      strobe_q     <= '0;
      rsp_data_q   <= '0;
      dreq_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
`ifdef MEM_MISALIGN_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q   <= aligned_addr;
            size_q   <= eff_size;
            ofs_q    <= req_ofs;
            uns_q    <= bus.req_unsigned;
            store_q  <= bus.req_store;
            data_q   <= bus.req_store ? st_data : '0;
            strobe_q <= bus.req_store ? st_strobe : '0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
`ifdef MEM_MISALIGN_EN
            if (misaligned) begin
              state_q     <= HOLD;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              misalign_q  <= 1'b1;
            end else begin
              state_q      <= REQ;
              dreq_valid_q <= 1'b1;
            end
`else
            state_q      <= REQ;
            dreq_valid_q <= 1'b1;
`endif
          end
        end
        REQ, DATA: begin
          if (bus.dresp_data_ok) begin
            state_q      <= HOLD;
            dreq_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= store_q ? '0 : ld_ext;
          end else if (state_q == REQ && bus.dresp_addr_ok) begin
            state_q <= DATA;
          end
        end
        HOLD: begin
          if (!bus.down_stall) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
`ifdef MEM_MISALIGN_EN
            misalign_q  <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.dreq_valid  = dreq_valid_q;
  assign bus.dreq_addr   = addr_q;
  assign bus.dreq_size   = size_q;
  assign bus.dreq_strobe = strobe_q;
  assign bus.dreq_data   = data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = busy_q;
`ifdef MEM_MISALIGN_EN
  assign bus.rsp_misalign = misalign_q;
`else
  assign bus.rsp_misalign = 1'b0;
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven and randomized check of mem_access_unit
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(64), .ADDR_W(64)) bus ();
  mem_access_unit #(.XLEN(64), .ADDR_W(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] dresp;
    int          na;
    int          nd;
    int          ns;
    logic [63:0] e_addr;
    logic [7:0]  e_strobe;
    logic [63:0] e_data;
    logic [63:0] e_rsp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] dresp,
                              input int na, input int nd, input int ns,
                              input logic [63:0] e_addr, input logic [7:0] e_strobe,
                              input logic [63:0] e_data, input logic [63:0] e_rsp);
    vec_t v;
    v.ld = ld; v.st = st; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.dresp = dresp; v.na = na; v.nd = nd; v.ns = ns; v.e_addr = e_addr;
    v.e_strobe = e_strobe; v.e_data = e_data; v.e_rsp = e_rsp;
    return v;
  endfunction

  // Byte-level reference: aligned address, lane strobes, placed store bytes, extended load value
  function automatic vec_t model(input vec_t vi);
    vec_t v = vi;
    int nb = 1 << v.size;
    int off;
    logic [63:0] r;
    v.e_addr   = v.addr - (v.addr % nb);
    off        = int'(v.e_addr % 8);
    v.e_strobe = '0;
    v.e_data   = '0;
    r          = '0;
    if (v.st) begin
      for (int i = 0; i < nb; i++) v.e_strobe[off + i] = 1'b1;
      for (int i = off; i < 8; i++) v.e_data[8*i +: 8] = v.wdata[8*(i-off) +: 8];
    end else begin
      for (int i = 0; i < nb; i++) r[8*i +: 8] = v.dresp[8*(off+i) +: 8];
      if (!v.uns && r[8*nb-1])
        for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    end
    v.e_rsp = r;
    return v;
  endfunction

  task automatic clear_req();
    bus.req_valid = 0; bus.req_load = 0; bus.req_store = 0;
    bus.req_size = 0; bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;
  endtask

  // One complete transaction; starts and ends at posedge+1 with the unit idle
  task automatic run_txn(input vec_t v, input string tag);
    logic [63:0] held;
    bus.req_valid = 1; bus.req_load = v.ld; bus.req_store = v.st; bus.req_size = v.size;
    bus.req_unsigned = v.uns; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    @(posedge clk); #1;
    clear_req();
    chk({tag, " dreq_valid"}, 64'(bus.dreq_valid), 64'd1);
    chk({tag, " dreq_addr"}, bus.dreq_addr, v.e_addr);
    chk({tag, " dreq_strobe"}, 64'(bus.dreq_strobe), 64'(v.e_strobe));
    if (v.st) chk({tag, " dreq_data"}, bus.dreq_data, v.e_data);
    chk({tag, " req_ready low"}, 64'(bus.req_ready), 64'd0);
    chk({tag, " busy"}, 64'(bus.busy), 64'd1);
    for (int k = 0; k < v.na; k++) begin
      @(posedge clk); #1;
      chk({tag, " dreq held REQ"}, {bus.dreq_addr[62:0], bus.dreq_valid}, {v.e_addr[62:0], 1'b1});
    end
    if (v.nd > 0) begin
      bus.dresp_addr_ok = 1;
      @(posedge clk); #1;
      bus.dresp_addr_ok = 0;
      chk({tag, " dreq held DATA"}, {bus.dreq_addr[62:0], bus.dreq_valid}, {v.e_addr[62:0], 1'b1});
      for (int k = 0; k < v.nd - 1; k++) begin
        @(posedge clk); #1;
        chk({tag, " dreq held DATA"}, 64'(bus.dreq_strobe) ^ 64'(bus.dreq_valid) << 8, 64'(v.e_strobe) | 64'h100);
      end
    end
    bus.dresp_data_ok = 1; bus.dresp_data = v.dresp;
    @(posedge clk); #1;
    bus.dresp_data_ok = 0; bus.dresp_data = {$urandom, $urandom};
    bus.down_stall = (v.ns > 0);
    chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({tag, " rsp_data"}, bus.rsp_data, v.e_rsp);
    chk({tag, " dreq_valid drop"}, 64'(bus.dreq_valid), 64'd0);
    held = bus.rsp_data;
    for (int k = 0; k < v.ns; k++) begin
      bus.dresp_data_ok = 1'($urandom);
      @(posedge clk); #1;
      chk({tag, " stall stable"}, {bus.rsp_data[61:0], bus.rsp_valid, bus.req_ready},
          {held[61:0], 1'b1, 1'b0});
    end
    bus.dresp_data_ok = 0; bus.down_stall = 0;
    @(posedge clk); #1;
    chk({tag, " back to idle"}, {61'd0, bus.rsp_valid, bus.req_ready, bus.busy}, 64'b010);
  endtask

  initial begin
    vec_t v;
    clear_req();
    bus.dresp_addr_ok = 0; bus.dresp_data_ok = 0; bus.dresp_data = 0; bus.down_stall = 0;
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset outputs", {bus.dreq_valid, bus.rsp_valid, bus.rsp_misalign, bus.busy, bus.req_ready}, 64'b00001);
    chk("reset data", bus.rsp_data | bus.dreq_addr | bus.dreq_data | 64'(bus.dreq_strobe), 64'd0);
    reset = 0;

    tbl[0] = mk(1, 0, 0, 0, 64'h1003, 0, 64'h0000_0000_8000_0000, 0, 0, 0, 64'h1003, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF80);
    tbl[1] = mk(0, 1, 1, 0, 64'h2006, 64'hABCD, 0, 3, 2, 0, 64'h2006, 8'hC0, 64'hABCD_0000_0000_0000, 0);
    tbl[2] = mk(1, 0, 2, 1, 64'h4, 0, 64'hF234_5678_0000_0000, 0, 1, 0, 64'h4, 8'h00, 0, 64'h0000_0000_F234_5678);
    tbl[3] = mk(1, 0, 3, 0, 64'h8, 0, 64'h1234_5678_9ABC_DEF0, 1, 0, 4, 64'h8, 8'h00, 0, 64'h1234_5678_9ABC_DEF0);
    tbl[4] = mk(1, 0, 1, 0, 64'h2, 0, 64'h0000_0000_8001_0000, 0, 0, 0, 64'h2, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001);
    tbl[5] = mk(1, 0, 0, 1, 64'h7, 0, 64'hFE00_0000_0000_0000, 2, 0, 1, 64'h7, 8'h00, 0, 64'hFE);
    tbl[6] = mk(0, 1, 3, 0, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 0, 64'h10, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 0);
    tbl[7] = mk(0, 1, 0, 0, 64'h5, 64'h1FF, 0, 0, 0, 0, 64'h5, 8'h20, 64'h0001_FF00_0000_0000, 0);
    tbl[8] = mk(1, 1, 2, 0, 64'h4, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'h4, 8'hF0, 64'h0000_0055_0000_0000, 0);
    tbl[9] = mk(1, 0, 2, 0, 64'h0, 0, 64'h0000_0000_8000_0000, 0, 3, 0, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_8000_0000);
    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Request with neither load nor store is ignored
    bus.req_valid = 1; bus.req_addr = 64'h40;
    @(posedge clk); #1;
    clear_req();
    chk("no-kind ignored", {61'd0, bus.dreq_valid, bus.busy, bus.req_ready}, 64'b001);

    // Asynchronous reset while in DATA, then a normal transaction
    bus.req_valid = 1; bus.req_store = 1; bus.req_size = 3; bus.req_addr = 64'h20; bus.req_wdata = 64'h99;
    @(posedge clk); #1;
    clear_req();
    bus.dresp_addr_ok = 1;
    @(posedge clk); #1;
    bus.dresp_addr_ok = 0;
    chk("pre-reset in DATA", 64'(bus.dreq_valid), 64'd1);
    #2 reset = 1;
    #1;
    chk("async reset drop", {61'd0, bus.dreq_valid, bus.busy, bus.req_ready}, 64'b001);
    @(posedge clk); #1;
    reset = 0;
    run_txn(tbl[2], "post-reset");

`ifdef MEM_MISALIGN_EN
    bus.req_valid = 1; bus.req_load = 1; bus.req_size = 2; bus.req_addr = 64'h1002;
    @(posedge clk); #1;
    clear_req();
    chk("misalign flags", {60'd0, bus.dreq_valid, bus.rsp_valid, bus.rsp_misalign, bus.busy}, 64'b0111);
    chk("misalign rsp_data", bus.rsp_data, 64'd0);
    @(posedge clk); #1;
    chk("misalign idle", {61'd0, bus.rsp_valid, bus.rsp_misalign, bus.req_ready}, 64'b001);
`else
    run_txn(mk(0, 1, 2, 0, 64'h1002, 64'h1122_3344, 0, 0, 0, 0, 64'h1000, 8'h0F, 64'h1122_3344, 0), "align-down");
    chk("misalign tied 0", 64'(bus.rsp_misalign), 64'd0);
`endif

    // Randomized transactions against the byte-level model
    for (int i = 0; i < 40; i++) begin
      v.size = 2'($urandom_range(0, 3));
      v.st   = 1'($urandom);
      v.ld   = v.st ? 1'($urandom) : 1'b1;
      v.uns  = 1'($urandom);
      v.addr = 64'($urandom_range(0, 16'hFFFF));
`ifdef MEM_MISALIGN_EN
      v.addr = v.addr & ~64'((1 << v.size) - 1);
`endif
      v.wdata = {$urandom, $urandom};
      v.dresp = {$urandom, $urandom};
      v.na = $urandom_range(0, 3);
      v.nd = $urandom_range(0, 3);
      v.ns = $urandom_range(0, 3);
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit for the memory stage of the pipeline. It accepts one memory operation per transaction from the execute/memory boundary and drives the data bus with a held request. Loads get lane extraction plus sign/zero extension; stores get the shifted write data and byte strobes. The response is captured in a result register and held until the downstream stage accepts it, so the pipeline can stall at any point without losing bus data.

## Interface
- XLEN, 64: data width in bits; legal values 32 or 64; NB = XLEN/8 byte lanes, OFS = log2(NB).
- ADDR_W, 64: address width.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory operation present.
- req_ready  out  1  unit idle; transfer accepted when req_valid & req_ready.
- req_load / req_store  in  1 each  operation kind; both high is treated as a store.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double.
- req_unsigned  in  1  zero-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- dreq_valid  out  1  bus request.
- dreq_addr  out  ADDR_W, dreq_size  out  2, dreq_strobe  out  NB, dreq_data  out  XLEN.
- dresp_addr_ok, dresp_data_ok  in  1 each; dresp_data  in  XLEN.
- down_stall  in  1  downstream stage cannot take the result.
- rsp_valid  out  1, rsp_data  out  XLEN  result (0 for stores).
- rsp_misalign  out  1  misaligned access flag (see Configuration).
- busy  out  1  state != IDLE; feeds the hazard unit.

## Operation
- FSM states: IDLE, REQ, DATA, HOLD.
- IDLE: req_ready=1. On accept, the unit registers addr, size, unsigned, kind, shifted data and strobe, then moves to REQ. A request with neither load nor store high is ignored.
- Store encoding: dreq_data = req_wdata << (8*addr[OFS-1:0]) with truncation to XLEN. Strobe = ((1<<(1<<size))-1) << addr[OFS-1:0], limited to NB bits. Loads drive strobe 0.
- REQ: dreq_valid=1 with all fields stable.
  - addr_ok without data_ok -> DATA.
  - data_ok (with or without addr_ok) -> HOLD, capturing data.
- DATA: dreq_valid stays 1 with fields unchanged, as the bus protocol requires the request to be held until data_ok. data_ok -> HOLD.
- Load extraction: shifted = dresp_data >> (8*offset). The result is extended from bit 8*(1<<size)-1, sign-extended unless req_unsigned. Size equal to OFS passes through unchanged.
- HOLD: rsp_valid=1 and rsp_data is stable. If down_stall=0 the result is consumed in that cycle and the next state is IDLE. If down_stall=1 the unit remains in HOLD.
- With XLEN=32, size 3 is treated as size 2.

## Timing
- Reset: state IDLE; dreq_valid, rsp_valid, rsp_misalign, busy = 0; rsp_data, dreq_addr, dreq_data, dreq_strobe = 0; req_ready = 1. Reset takes effect immediately (asynchronous).
- Reset mid-transaction abandons it. The bus slave shares the same reset.
- dreq_valid rises the cycle after accept.
- Minimum latency is 2 cycles from the accept edge to rsp_valid: data_ok in the first REQ cycle gives rsp_valid in the next cycle.
- Each cycle of data_ok delay adds one cycle.
- Back-to-back: a new accept is possible in the cycle after HOLD is consumed, because req_ready is a registered function of state IDLE. Throughput is therefore one access per 3 cycles at best.
- dresp_* is ignored outside REQ/DATA.
- rsp_data is registered and never changes while rsp_valid=1.

## Configuration
- MEM_MISALIGN_EN defined:
  - An access whose addr is not a multiple of (1<<size) raises no bus request.
  - The unit goes IDLE -> HOLD directly, with rsp_valid=1, rsp_misalign=1, rsp_data=0 one cycle after accept.
- Not defined:
  - rsp_misalign is tied 0.
  - Address bits below size are cleared before encoding, so the access is aligned down.

## Test plan
- Signed byte load: XLEN=64, addr 0x1003, size 0, unsigned 0, dresp_data 0x00000000_80000000, data_ok in the first REQ cycle -> dreq_addr 0x1003, rsp_data 0xFFFF_FFFF_FFFF_FF80, rsp_valid 2 cycles after accept.
- Half store: addr 0x2006, size 1, wdata 0xABCD -> dreq_strobe 0xC0, dreq_data 0xABCD_0000_0000_0000. dreq_valid is held through 3 cycles of addr_ok=0 and then 2 cycles in DATA; rsp_data=0.
- Unsigned word load: addr 0x4, dresp_data 0xF234_5678_0000_0000 -> rsp_data 0x0000_0000_F234_5678.
- Downstream stall: down_stall=1 for 4 cycles after data_ok -> rsp_valid and rsp_data stay stable, req_ready stays 0. IDLE is entered the cycle after down_stall falls.
- Reset asserted while in DATA -> dreq_valid and busy drop the same cycle, and the next request completes normally.
- Misalignment: word load at 0x1002 with MEM_MISALIGN_EN -> no dreq_valid, rsp_misalign=1 the cycle after accept. Without the macro -> dreq_addr 0x1000 and strobe 0x0F for a store.
